// File: rtl/csa_stream_accumulator.sv
// Streaming carry-save accumulator: N operands per beat fold into a redundant (sum, carry)
// pair, resolved once per frame. Define CSA_SAT_EN to clamp overflowed results to all ones.
module csa_stream_accumulator #(
   parameter int N     = 5,
   parameter int W     = 14,
   parameter int ACC_W = 24,
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_last,
   input  logic [N*W-1:0]     in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ACC_W-1:0]   out_sum,
   output logic               out_ovf,
   output logic [CNT_W-1:0]   out_cnt
);

   typedef enum logic [1:0] {ACCUM, RESOLVE, HOLD} state_t;

   state_t             state;
   logic [ACC_W-1:0]   sum_p0;
   logic [ACC_W-1:0]   car_p0;
   logic               ovf_p0;
   logic [CNT_W-1:0]   cnt_p0;

   logic [ACC_W-1:0]   sum_nx;
   logic [ACC_W-1:0]   car_nx;
   logic               drop_nx;
   logic [ACC_W:0]     cpa;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   function automatic logic [ACC_W-1:0] sat_result(input logic [ACC_W-1:0] r, input logic ovf);
`ifdef CSA_SAT_EN
      return ovf ? {ACC_W{1'b1}} : r;
`else
      return (ovf & 1'b0) ? '0 : r;
`endif
   endfunction

   // Chain of 3:2 compressors folding each operand into the (sum, carry) rows. A carry that
   // would leave bit ACC_W-1 is worth 2^ACC_W, so dropping it proves the true sum overflows.
   always_comb begin
      logic [ACC_W-1:0] op;
      logic [ACC_W-1:0] maj;
      sum_nx  = sum_p0;
      car_nx  = car_p0;
      drop_nx = 1'b0;
      for (int k = 0; k < N; k++) begin
         op         = '0;
         op[W-1:0]  = in_data[k*W +: W];
         maj        = (sum_nx & car_nx) | (sum_nx & op) | (car_nx & op);
         drop_nx    = drop_nx | maj[ACC_W-1];
         sum_nx     = sum_nx ^ car_nx ^ op;
         car_nx     = maj << 1;
      end
   end

   assign cpa = {1'b0, sum_p0} + {1'b0, car_p0};

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ACCUM;
         sum_p0    <= '0;
         car_p0    <= '0;
         ovf_p0    <= 1'b0;
         cnt_p0    <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_ovf   <= 1'b0;
         out_cnt   <= '0;
      end else begin
         case (state)
            ACCUM: begin
               if (in_valid && in_ready) begin
                  sum_p0 <= sum_nx;
                  car_p0 <= car_nx;
                  ovf_p0 <= ovf_p0 | drop_nx;
                  cnt_p0 <= sat_inc(cnt_p0);
                  if (in_last) begin
                     state    <= RESOLVE;
                     in_ready <= 1'b0;
                  end
               end
            end
            // Single carry-propagate add; accumulator clears for the next frame.
            RESOLVE: begin
               out_sum   <= sat_result(cpa[ACC_W-1:0], ovf_p0 | cpa[ACC_W]);
               out_ovf   <= ovf_p0 | cpa[ACC_W];
               out_cnt   <= cnt_p0;
               out_valid <= 1'b1;
               sum_p0    <= '0;
               car_p0    <= '0;
               ovf_p0    <= 1'b0;
               cnt_p0    <= '0;
               state     <= HOLD;
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= ACCUM;
               end
            end
            default: begin
               state    <= ACCUM;
               in_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Scoreboard bench for csa_stream_accumulator: a bench-side running true sum predicts each frame.
module tb_csa_stream_accumulator;
   localparam int N     = 5;
   localparam int W     = 14;
   localparam int ACC_W = 24;
   localparam int CNT_W = 8;

   typedef struct {
      logic [ACC_W-1:0] sum;
      logic             ovf;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic               in_last;
   logic [N*W-1:0]     in_data;
   logic               out_valid;
   logic               out_ready;
   logic [ACC_W-1:0]   out_sum;
   logic               out_ovf;
   logic [CNT_W-1:0]   out_cnt;

   int     nvec = 0;
   int     nerr = 0;
   longint model_sum = 0;
   int     model_cnt = 0;
   exp_t   sb[$];

   csa_stream_accumulator #(.N(N), .W(W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_ovf(out_ovf), .out_cnt(out_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [N*W-1:0] pack5(input int a, input int b, input int c, input int d, input int e);
      logic [N*W-1:0] r;
      r = '0;
      r[0*W +: W] = W'(a);
      r[1*W +: W] = W'(b);
      r[2*W +: W] = W'(c);
      r[3*W +: W] = W'(d);
      r[4*W +: W] = W'(e);
      return r;
   endfunction

   function automatic logic [N*W-1:0] fill(input int v);
      return pack5(v, v, v, v, v);
   endfunction

   // Drives one beat, waits (bounded) for in_ready, updates the model and pushes on in_last.
   task automatic send_beat(input logic [N*W-1:0] d, input logic last);
      int   guard;
      exp_t e;
      guard = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (in_ready !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      nvec++;
      if (in_ready !== 1'b1) begin
         nerr++;
         $display("FAIL beat_accept: in_ready=%b, want 1", in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      for (int k = 0; k < N; k++) model_sum += longint'(d[k*W +: W]);
      model_cnt = (model_cnt == (1 << CNT_W) - 1) ? model_cnt : model_cnt + 1;
      if (last) begin
         e.ovf = (model_sum >= (longint'(1) << ACC_W));
         e.sum = model_sum[ACC_W-1:0];
`ifdef CSA_SAT_EN
         if (e.ovf) e.sum = {ACC_W{1'b1}};
`endif
         e.cnt = CNT_W'(model_cnt);
         sb.push_back(e);
         model_sum = 0;
         model_cnt = 0;
      end
   endtask

   task automatic wait_valid(output logic ok);
      int guard;
      guard = 0;
      while (out_valid !== 1'b1 && guard < 20) begin
         @(posedge clk);
         #1;
         guard++;
      end
      ok = (out_valid === 1'b1);
   endtask

   task automatic pop_exp(output exp_t e);
      e.sum = '0;
      e.ovf = 1'b0;
      e.cnt = '0;
      if (sb.size() > 0) e = sb.pop_front();
   endtask

   task automatic accept_out();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_sum = 0;
      model_cnt = 0;
      sb.delete();
      nvec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         nerr++;
         $display("FAIL reset_hs: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
      end
      nvec++;
      if (out_sum !== '0 || out_ovf !== 1'b0 || out_cnt !== '0) begin
         nerr++;
         $display("FAIL reset_out: sum=%0d ovf=%b cnt=%0d, want 0 0 0", out_sum, out_ovf, out_cnt);
      end
   endtask

   task automatic test_single_beat();
      exp_t e;
      logic ok;
      send_beat(fill(16383), 1'b1);
      nvec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         nerr++;
         $display("FAIL single_resolve: out_valid=%b in_ready=%b, want 0 0", out_valid, in_ready);
      end
      @(posedge clk);
      #1;
      nvec++;
      if (out_valid !== 1'b1) begin
         nerr++;
         $display("FAIL single_latency: out_valid=%b, want 1", out_valid);
      end
      wait_valid(ok);
      pop_exp(e);
      nvec++;
      if (!ok || out_sum !== e.sum || out_ovf !== e.ovf || out_cnt !== e.cnt || e.sum !== 24'd81915) begin
         nerr++;
         $display("FAIL single_result: sum=%0d ovf=%b cnt=%0d, want %0d %b %0d", out_sum, out_ovf, out_cnt, e.sum, e.ovf, e.cnt);
      end
      accept_out();
   endtask

   task automatic test_back_to_back();
      exp_t e;
      logic ok;
      for (int b = 0; b < 3; b++) send_beat(pack5(1, 2, 3, 4, 5), b == 2);
      wait_valid(ok);
      pop_exp(e);
      nvec++;
      if (!ok || out_sum !== e.sum || out_ovf !== e.ovf || out_cnt !== e.cnt || e.sum !== 24'd45) begin
         nerr++;
         $display("FAIL three_beat: sum=%0d ovf=%b cnt=%0d, want %0d %b %0d", out_sum, out_ovf, out_cnt, e.sum, e.ovf, e.cnt);
      end
      accept_out();
      nvec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         nerr++;
         $display("FAIL b2b_ready: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
      end
      send_beat(pack5(7, 0, 9, 0, 1000), 1'b1);
      wait_valid(ok);
      pop_exp(e);
      nvec++;
      if (!ok || out_sum !== e.sum || out_ovf !== e.ovf || out_cnt !== e.cnt) begin
         nerr++;
         $display("FAIL b2b_result: sum=%0d ovf=%b cnt=%0d, want %0d %b %0d", out_sum, out_ovf, out_cnt, e.sum, e.ovf, e.cnt);
      end
      accept_out();
   endtask

   task automatic test_overflow();
      exp_t e;
      logic ok;
      logic [ACC_W-1:0] want;
`ifdef CSA_SAT_EN
      want = 24'd16777215;
`else
      want = 24'd15359;
`endif
      for (int b = 0; b < 205; b++) send_beat(fill(16383), b == 204);
      wait_valid(ok);
      pop_exp(e);
      nvec++;
      if (!ok || out_sum !== e.sum || out_sum !== want || out_ovf !== 1'b1 || out_cnt !== 8'd205) begin
         nerr++;
         $display("FAIL overflow: sum=%0d ovf=%b cnt=%0d, want %0d 1 205", out_sum, out_ovf, out_cnt, want);
      end
      accept_out();
   endtask

   task automatic test_backpressure();
      exp_t e;
      logic ok;
      send_beat(pack5(10, 20, 30, 40, 50), 1'b0);
      send_beat(pack5(10, 20, 30, 40, 50), 1'b1);
      wait_valid(ok);
      pop_exp(e);
      nvec++;
      if (!ok || e.sum !== 24'd300) begin
         nerr++;
         $display("FAIL bp_valid: out_valid=%b model=%0d, want 1 300", out_valid, e.sum);
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_last  = 1'b1;
         in_data  = fill(999 + c);
         @(posedge clk);
         #1;
         nvec++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== e.sum || out_ovf !== e.ovf || out_cnt !== e.cnt) begin
            nerr++;
            $display("FAIL bp_hold: valid=%b rdy=%b sum=%0d ovf=%b cnt=%0d, want 1 0 %0d %b %0d",
                     out_valid, in_ready, out_sum, out_ovf, out_cnt, e.sum, e.ovf, e.cnt);
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      accept_out();
      nvec++;
      if (in_ready !== 1'b1) begin
         nerr++;
         $display("FAIL bp_release: in_ready=%b, want 1", in_ready);
      end
      send_beat(pack5(1, 0, 0, 0, 0), 1'b1);
      wait_valid(ok);
      pop_exp(e);
      nvec++;
      if (!ok || out_sum !== 24'd1 || out_cnt !== 8'd1 || out_ovf !== 1'b0) begin
         nerr++;
         $display("FAIL bp_next: sum=%0d ovf=%b cnt=%0d, want 1 0 1", out_sum, out_ovf, out_cnt);
      end
      accept_out();
   endtask

   task automatic test_reset_midframe();
      exp_t e;
      logic ok;
      send_beat(fill(100), 1'b0);
      send_beat(fill(100), 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_sum = 0;
      model_cnt = 0;
      send_beat(fill(1), 1'b1);
      wait_valid(ok);
      pop_exp(e);
      nvec++;
      if (!ok || out_sum !== 24'd5 || out_cnt !== 8'd1 || out_ovf !== 1'b0 || out_sum !== e.sum) begin
         nerr++;
         $display("FAIL rst_midframe: sum=%0d ovf=%b cnt=%0d, want 5 0 1", out_sum, out_ovf, out_cnt);
      end
      accept_out();
   endtask

   task automatic test_cnt_saturation();
      exp_t e;
      logic ok;
      for (int b = 0; b < 300; b++) send_beat(fill(0), b == 299);
      wait_valid(ok);
      pop_exp(e);
      nvec++;
      if (!ok || out_cnt !== 8'd255 || out_sum !== 24'd0 || out_ovf !== 1'b0 || out_cnt !== e.cnt) begin
         nerr++;
         $display("FAIL cnt_sat: sum=%0d ovf=%b cnt=%0d, want 0 0 255", out_sum, out_ovf, out_cnt);
      end
      accept_out();
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      test_reset();
      test_single_beat();
      test_back_to_back();
      test_overflow();
      test_backpressure();
      test_reset_midframe();
      test_cnt_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
